// File: rtl/pat_gen_cfg_pkg.sv
// rtl/pat_gen_cfg_pkg.sv - shared types and width helpers for the pattern-generator config master
package pat_gen_cfg_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pat_gen_shadow_bank.sv
// rtl/pat_gen_shadow_bank.sv - host-loaded shadow register file, sync write / async read
module pat_gen_shadow_bank #(
  parameter int NUM_REGS   = 21,
  parameter int DATA_WIDTH = 12,
  parameter int IDXW       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDXW-1:0]       wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0]       rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en && (32'(wr_idx) < NUM_REGS)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Indices past the bank read as zero so the look-ahead port never goes out of range.
  assign rd_data = (32'(rd_idx) < NUM_REGS) ? mem[rd_idx] : '0;

endmodule

// File: rtl/pat_gen_cfg_master.sv
// rtl/pat_gen_cfg_master.sv - streams the shadow bank to the pattern-generator target on start
module pat_gen_cfg_master
  import pat_gen_cfg_pkg::*;
#(
  parameter int                    ADDR_WIDTH          = 32,
  parameter int                    DATA_WIDTH          = 12,
  parameter int                    NUM_REGS            = 21,
  parameter int                    SUB_REGS_DATA_WIDTH = max_width(ADDR_WIDTH, DATA_WIDTH),
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR           = '0,
  parameter int                    ADDR_STRIDE         = 4,
  parameter int                    TIMEOUT             = 255,
  localparam int                   IDXW                = clog2_min1(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_en_i,
  input  logic [IDXW-1:0]                wr_idx_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic                           nopg_i,
  output logic [ADDR_WIDTH-1:0]          si_addr_o,
  output logic [SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_o,
  output logic                           cfg_pat_gen_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int                    TW     = 16;
  localparam logic [TW-1:0]         TLAST  = TW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0]       ILAST  = IDXW'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

  state_t                state;
  logic [IDXW-1:0]       idx;
  logic [IDXW-1:0]       rd_idx;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  accept;

  // The bank is read one index ahead so the next beat can be registered on accept.
  assign rd_idx = (state == ISSUE) ? idx + 1'b1 : '0;
  assign accept = cfg_pat_gen_o && !nopg_i;

  pat_gen_shadow_bank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDXW      (IDXW)
  ) u_bank (
    .clk    (clk_i),
    .rst    (rst_i),
    .wr_en  (wr_en_i),
    .wr_idx (wr_idx_i),
    .wr_data(wr_data_i),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      idx            <= '0;
      tcnt           <= '0;
      si_addr_o      <= '0;
      ctl_pat_data_o <= '0;
      cfg_pat_gen_o  <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            state          <= ISSUE;
            idx            <= '0;
            tcnt           <= '0;
            si_addr_o      <= BASE_ADDR;
            ctl_pat_data_o <= SUB_REGS_DATA_WIDTH'(rd_data);
            cfg_pat_gen_o  <= 1'b1;
            busy_o         <= 1'b1;
            err_o          <= 1'b0;
          end
        end
        ISSUE: begin
          if (abort_i) begin
            state         <= IDLE;
            cfg_pat_gen_o <= 1'b0;
            busy_o        <= 1'b0;
            tcnt          <= '0;
          end else if (accept) begin
            tcnt <= '0;
            if (idx == ILAST) begin
              state         <= DONE;
              cfg_pat_gen_o <= 1'b0;
              done_o        <= 1'b1;
            end else begin
              idx            <= idx + 1'b1;
              si_addr_o      <= si_addr_o + STRIDE;
              ctl_pat_data_o <= SUB_REGS_DATA_WIDTH'(rd_data);
            end
          end else if (tcnt == TLAST) begin
            state         <= IDLE;
            cfg_pat_gen_o <= 1'b0;
            busy_o        <= 1'b0;
            err_o         <= 1'b1;
            tcnt          <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pat_gen_cfg_master.sv
// tb/tb_pat_gen_cfg_master.sv - scoreboard bench for pat_gen_cfg_master
module tb_pat_gen_cfg_master;

  localparam int NR = 21;
  localparam int TO = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, abort, nopg;
  logic [4:0]  wr_idx;
  logic [11:0] wr_data;
  logic [31:0] si_addr, pat_data;
  logic        cfg, busy, done, err;

  logic [11:0] sh [NR];
  beat_t       exp_q [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  pat_gen_cfg_master #(.TIMEOUT(TO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_en_i       (wr_en),
    .wr_idx_i      (wr_idx),
    .wr_data_i     (wr_data),
    .start_i       (start),
    .abort_i       (abort),
    .nopg_i        (nopg),
    .si_addr_o     (si_addr),
    .ctl_pat_data_o(pat_data),
    .cfg_pat_gen_o (cfg),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic host_wr(input int i, input logic [11:0] d);
    wr_en = 1'b1; wr_idx = 5'(i); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (i < NR) sh[i] = d;
  endtask

  // Drives one sequence with optional stall / abort / reset / ignored-start events keyed on beat count.
  task automatic run_seq(input string nm, input int stall_at, input int stall_len,
                         input int abort_at, input int rst_at, input int restart_at,
                         output int done_cyc, output int ndone, output int beats,
                         output int end_cyc);
    int cyc, stalled;
    bit fa, fr, fs;
    beat_t e;
    exp_q.delete();
    for (int i = 0; i < NR; i++) exp_q.push_back('{addr: 32'(i * 4), data: 32'(sh[i])});
    done_cyc = -1; ndone = 0; beats = 0; end_cyc = -1;
    cyc = 0; stalled = 0; fa = 0; fr = 0; fs = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 300) begin
      cyc++;
      nopg = (beats == stall_at) && (stalled < stall_len);
      if (nopg) stalled++;
      abort = (beats == abort_at) && !fa;
      if (abort) fa = 1;
      rst = (beats == rst_at) && !fr;
      if (rst) fr = 1;
      start = (beats == restart_at) && !fs;
      if (start) fs = 1;
      @(negedge clk);
      if (cyc == 1) begin
        chk({nm, "_first_valid"}, 64'(cfg), 64'd1);
        chk({nm, "_err_clear"}, 64'(err), 64'd0);
      end
      if (done) begin ndone++; done_cyc = cyc; end
      if (cyc > 1 && !busy) begin end_cyc = cyc; break; end
      if (cfg && exp_q.size() == 0) begin
        chk({nm, "_extra_beat"}, 64'(si_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else if (cfg) begin
        e = exp_q[0];
        chk({nm, "_addr"}, 64'(si_addr), 64'(e.addr));
        chk({nm, "_data"}, 64'(pat_data), 64'(e.data));
        if (!nopg && !abort && !rst) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
      @(posedge clk); #1;
    end
    nopg = 1'b0; abort = 1'b0; rst = 1'b0; start = 1'b0;
    if (end_cyc < 0) chk({nm, "_cycle_bound"}, 64'd0, 64'd1);
  endtask

  task automatic run_normal(input string nm);
    int dc, nd, bt, ec;
    run_seq(nm, -1, 0, -1, -1, -1, dc, nd, bt, ec);
    chk({nm, "_beats"}, 64'(bt), 64'(NR));
    chk({nm, "_done_cycle"}, 64'(dc), 64'(NR + 1));
    chk({nm, "_done_count"}, 64'(nd), 64'd1);
    chk({nm, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int dc, nd, bt, ec;
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    start = 1'b0; abort = 1'b0; nopg = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_addr", 64'(si_addr), 64'd0);
    chk("rst_data", 64'(pat_data), 64'd0);
    chk("rst_cfg", 64'(cfg), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    for (int i = 0; i < NR; i++) host_wr(i, 12'(i + 1));
    run_normal("plain");

    run_seq("stall", 5, 3, -1, -1, -1, dc, nd, bt, ec);
    chk("stall_beats", 64'(bt), 64'(NR));
    chk("stall_done_cycle", 64'(dc), 64'(NR + 4));
    chk("stall_done_count", 64'(nd), 64'd1);

    run_seq("tmo", 2, 1000, -1, -1, -1, dc, nd, bt, ec);
    chk("tmo_beats", 64'(bt), 64'd2);
    chk("tmo_end_cycle", 64'(ec), 64'(3 + TO));
    chk("tmo_done_count", 64'(nd), 64'd0);
    chk("tmo_cfg", 64'(cfg), 64'd0);
    chk("tmo_err", 64'(err), 64'd1);
    run_normal("after_tmo");

    run_seq("abort", -1, 0, 10, -1, -1, dc, nd, bt, ec);
    chk("abort_beats", 64'(bt), 64'd10);
    chk("abort_end_cycle", 64'(ec), 64'd12);
    chk("abort_done_count", 64'(nd), 64'd0);
    chk("abort_cfg", 64'(cfg), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    run_normal("after_abort");

    host_wr(21, 12'hFFF);
    run_seq("restart", -1, 0, -1, -1, 8, dc, nd, bt, ec);
    chk("restart_beats", 64'(bt), 64'(NR));
    chk("restart_done_cycle", 64'(dc), 64'(NR + 1));
    chk("restart_done_count", 64'(nd), 64'd1);

    run_seq("midrst", -1, 0, -1, 7, -1, dc, nd, bt, ec);
    chk("midrst_beats", 64'(bt), 64'd7);
    chk("midrst_end_cycle", 64'(ec), 64'd9);
    chk("midrst_addr", 64'(si_addr), 64'd0);
    chk("midrst_data", 64'(pat_data), 64'd0);
    chk("midrst_cfg", 64'(cfg), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    for (int i = 0; i < NR; i++) sh[i] = '0;
    run_normal("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pat_gen_cfg_master.md
Name: pat_gen_cfg_master

Overview:
- Initiator side of the pattern-generator configuration interface; drives si_addr / ctl_pat_data / cfg_pat_gen into the pattern-generator target and honours its nopg busy indication.
- Holds a local shadow bank of NUM_REGS data words loaded by the host.
- On a start pulse, streams all registers to the target in index order, one write per accepted beat, then reports done.

Parameters:
- ADDR_WIDTH, 32, target address width.
- DATA_WIDTH, 12, shadow register data width.
- NUM_REGS, 21, number of registers streamed per sequence; legal range 1..255.
- SUB_REGS_DATA_WIDTH, (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH, width of the outgoing data bus.
- BASE_ADDR, 32'h0000_0000, address of register 0.
- ADDR_STRIDE, 4, address increment per register.
- TIMEOUT, 255, maximum number of consecutive busy cycles tolerated per beat; legal range 1..65535.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- wr_en_i  in  1  host shadow write strobe.
- wr_idx_i  in  IDXW = $clog2(NUM_REGS) (minimum 1)  shadow index.
- wr_data_i  in  DATA_WIDTH  shadow write data.
- start_i  in  1  start-sequence pulse.
- abort_i  in  1  abort the running sequence.
- nopg_i  in  1  target busy; high means the current beat is not accepted.
- si_addr_o  out  ADDR_WIDTH  target register address.
- ctl_pat_data_o  out  SUB_REGS_DATA_WIDTH  write data, zero-extended from DATA_WIDTH.
- cfg_pat_gen_o  out  1  write valid.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky timeout flag; cleared by start_i or rst_i.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE, index counter 0, timeout counter 0.
  - Shadow bank cleared to 0.
- Shadow bank:
  - Writable in any state.
  - A write with wr_idx_i >= NUM_REGS is ignored.
  - A write to the index currently presented on the bus takes effect only on the next sequence; the beat holds its data registered at ISSUE entry.
- FSM states:
  - IDLE:
    - start_i -> ISSUE with idx=0; clear err_o.
    - busy_o=0.
  - ISSUE:
    - Outputs are registered: cfg_pat_gen_o=1, si_addr_o=BASE_ADDR+idx*ADDR_STRIDE (modulo 2^ADDR_WIDTH), ctl_pat_data_o=shadow[idx].
    - A beat is accepted on a clock edge where cfg_pat_gen_o=1 and nopg_i=0.
    - On accept, if idx==NUM_REGS-1 -> DONE; otherwise idx+1, stay in ISSUE, and present the next beat on the following cycle (back-to-back, one beat per cycle when nopg_i stays low).
    - While nopg_i=1, addr, data and valid are held stable and the timeout counter increments.
    - When the counter reaches TIMEOUT -> IDLE with err_o=1 and cfg_pat_gen_o=0; done_o is not pulsed.
    - The timeout counter resets on each accepted beat.
  - DONE:
    - done_o=1 for exactly one cycle, cfg_pat_gen_o=0 -> IDLE.
- busy_o=1 in ISSUE and DONE.
- Latency:
  - First beat valid in the cycle after start_i is sampled.
  - Minimum sequence time is NUM_REGS+1 cycles from start_i to the done_o pulse.
- start_i while busy_o=1 is ignored.
- abort_i in ISSUE or DONE:
  - Next cycle IDLE, cfg_pat_gen_o=0, no done_o, err_o unchanged.
  - abort_i has priority over accept, timeout and done.
- start_i and abort_i in the same IDLE cycle: abort wins; stay in IDLE.
- NUM_REGS=1: single beat, then DONE.
- rst_i mid-sequence: immediate return to reset values on the next edge; the shadow bank is also cleared.

Decomposition:
- Package pat_gen_cfg_pkg:
  - state enum {IDLE, ISSUE, DONE}.
  - Function clog2_min1.
  - Function for the SUB_REGS_DATA_WIDTH max.
- One sub-module, pat_gen_shadow_bank:
  - NUM_REGS x DATA_WIDTH register file.
  - Synchronous write port, asynchronous read by index.
- Top module holds the FSM, index counter, timeout counter and output registers.

Test Plan:
- Load shadow[i]=i+1 (i=0..20), start_i, nopg_i=0 -> 21 consecutive beats, addr 0x0, 0x4 ... 0x50, data 0x001 ... 0x015 zero-extended to 32 bits; done_o pulses at cycle 22 after start.
- Same sequence with nopg_i=1 for 3 cycles at beat 5 -> beat 5 addr/data held for 4 cycles, no skipped or duplicated beat, done_o delayed by 3 cycles.
- TIMEOUT=4, nopg_i held high from beat 2 -> after 4 busy cycles cfg_pat_gen_o=0, err_o=1, no done_o; a following start_i clears err_o and completes normally.
- abort_i asserted at beat 10 -> cfg_pat_gen_o=0 the next cycle, busy_o=0, no done_o; start_i then restarts from addr 0x0.
- wr_idx_i=21 with wr_data_i=0xFFF, then a sequence -> no beat carries 0xFFF; start_i pulsed mid-sequence -> ignored, still 21 beats.
- rst_i asserted at beat 7 -> all outputs 0 next cycle; a sequence afterwards shows all data 0 (shadow bank cleared).
